fnd_share_scheduler: RTL and testbench

- Time-multiplexed 4-digit FND scan controller that shares one display between two value sources.
- Source 0: free-running primary count, e.g. the I2C timer-slave counter value.
- Source 1: request/acknowledge message channel, e.g. status or error codes from the AXI/I2C master side. It preempts source 0 for a programmable hold time.
- Adds inter-digit blanking (anti-ghosting), frame-synchronous value update, saturation and optional leading-zero suppression.
- Drives the board FND pins directly.

---
 rtl/fnd_share_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_fnd_share_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fnd_share_scheduler.sv
// Four-digit multiplexed FND driver shared between a free-running count (source 0)
// and a request/acknowledge message channel (source 1) that preempts it for a hold time.
module fnd_share_scheduler #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLANK_CYC  = 16,
  parameter int HOLD_TICKS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] cnt0,
  input  logic        req1,
  input  logic [13:0] val1,
  input  logic        lz_en,
  output logic        ack1,
  output logic        sel,
  output logic [7:0]  fnd_data,
  output logic [3:0]  fnd_com
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int HW  = $clog2(HOLD_TICKS + 1);

  localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYC - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(1);
  localparam logic [13:0]   SAT_MAX    = 14'd9999;

  typedef enum logic { SHOW, BLANK } scan_t;
  typedef enum logic { PRIM, HOLD }  arb_t;

  scan_t          scan;
  arb_t           arb;
  logic [PW-1:0]  presc;
  logic           tick;
  logic [1:0]     idx;
  logic [BW-1:0]  blank_cnt;
  logic [HW-1:0]  hold_cnt;
  logic [13:0]    held_val1;
  logic [13:0]    disp_val;
  logic           sel_src;
  logic [13:0]    src_val;
  logic [13:0]    next_val;
  logic [15:0]    bcd;
  logic [3:0]     digit;
  logic           lz_blank;

  function automatic logic [15:0] to_bcd(input logic [13:0] v);
    logic [29:0] sh;
    sh = {16'd0, v};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sh[14+4*d +: 4] >= 4'd5) sh[14+4*d +: 4] = sh[14+4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    return sh[29:14];
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0] com_code(input logic [1:0] i);
    case (i)
      2'd0:    return 4'b1110;
      2'd1:    return 4'b1101;
      2'd2:    return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // Scan tick: one clock wide on the prescaler terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick     = (presc == PRESC_MAX);
  assign sel_src  = (arb == HOLD);
  assign src_val  = sel_src ? held_val1 : cnt0;
  assign next_val = (src_val > SAT_MAX) ? SAT_MAX : src_val;

  // Digit scan; the displayed value only changes when the index wraps back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan      <= SHOW;
      idx       <= 2'd0;
      blank_cnt <= '0;
      disp_val  <= 14'd0;
      sel       <= 1'b0;
    end else begin
      case (scan)
        SHOW: begin
          if (tick) begin
            scan      <= BLANK;
            blank_cnt <= BLANK_LOAD;
          end
        end
        BLANK: begin
          if (blank_cnt == '0) begin
            idx  <= idx + 2'd1;
            scan <= SHOW;
            if (idx == 2'd3) begin
              disp_val <= next_val;
              sel      <= sel_src;
            end
          end else begin
            blank_cnt <= blank_cnt - 1'b1;
          end
        end
        default: scan <= SHOW;
      endcase
    end
  end

  // Source-1 handshake: req1 is a level sampled every clock and is always accepted;
  // ack1 is the registered acceptance, one clock after each sampled-high req1.
  always_ff @(posedge clk) begin
    if (rst) begin
      arb       <= PRIM;
      hold_cnt  <= '0;
      held_val1 <= 14'd0;
      ack1      <= 1'b0;
    end else begin
      ack1 <= req1;
      case (arb)
        PRIM: begin
          if (req1) begin
            held_val1 <= val1;
            hold_cnt  <= HOLD_LOAD;
            arb       <= HOLD;
          end
        end
        HOLD: begin
          if (req1) begin
            held_val1 <= val1;
            hold_cnt  <= HOLD_LOAD;
          end else if (tick) begin
            hold_cnt <= hold_cnt - 1'b1;
            if (hold_cnt == HOLD_LAST) arb <= PRIM;
          end
        end
        default: arb <= PRIM;
      endcase
    end
  end

  assign bcd = to_bcd(disp_val);

  always_comb begin
    digit    = bcd[3:0];
    lz_blank = 1'b0;
    case (idx)
      2'd0: begin
        digit    = bcd[3:0];
        lz_blank = 1'b0;
      end
      2'd1: begin
        digit    = bcd[7:4];
        lz_blank = lz_en && (bcd[15:4] == 12'd0);
      end
      2'd2: begin
        digit    = bcd[11:8];
        lz_blank = lz_en && (bcd[15:8] == 8'd0);
      end
      default: begin
        digit    = bcd[15:12];
        lz_blank = lz_en && (bcd[15:12] == 4'd0);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fnd_com  <= 4'b1111;
      fnd_data <= 8'hFF;
    end else if (scan == SHOW) begin
      fnd_com  <= com_code(idx);
      fnd_data <= lz_blank ? 8'hFF : seg_code(digit);
    end else begin
      fnd_com  <= 4'b1111;
      fnd_data <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_fnd_share_scheduler.sv
// Bench for fnd_share_scheduler: directed scenarios plus random traffic, every clock
// compared against a timing model derived from cycle arithmetic.
module tb_fnd_share_scheduler;

  localparam int CLK_HZ     = 1000;
  localparam int SCAN_HZ    = 100;
  localparam int BLANK_CYC  = 2;
  localparam int HOLD_TICKS = 8;
  localparam int DIV        = CLK_HZ / SCAN_HZ;

  logic        clk;
  logic        rst;
  logic [13:0] cnt0;
  logic        req1;
  logic [13:0] val1;
  logic        lz_en;
  logic        ack1;
  logic        sel;
  logic [7:0]  fnd_data;
  logic [3:0]  fnd_com;

  fnd_share_scheduler #(
    .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_CYC(BLANK_CYC), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .cnt0(cnt0), .req1(req1), .val1(val1), .lz_en(lz_en),
    .ack1(ack1), .sel(sel), .fnd_data(fnd_data), .fnd_com(fnd_com)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [3:0] com_tab [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int         pow10 [4]    = '{1, 10, 100, 1000};

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: n counts clocks since reset release; last_req is the cycle of the
  // most recent request (-1 when none since reset).
  int         n        = 0;
  int         last_req = -1;
  int         last_val = 0;
  int         m_disp   = 0;
  logic       m_sel    = 1'b0;
  logic [3:0] e_com;
  logic [7:0] e_data;
  logic       e_ack;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n);
  endtask

  task automatic step();
    int   idx;
    int   v;
    logic show;
    logic src;
    @(posedge clk);
    if (rst) begin
      e_com    = 4'b1111;
      e_data   = 8'hFF;
      e_ack    = 1'b0;
      m_sel    = 1'b0;
      m_disp   = 0;
      n        = 0;
      last_req = -1;
    end else begin
      // Digit period is DIV clocks; the first BLANK_CYC clocks of each later period are blank.
      if (n < DIV) begin
        show = 1'b1;
        idx  = 0;
      end else begin
        show = ((n % DIV) >= BLANK_CYC);
        idx  = (n / DIV) % 4;
      end
      if (show) begin
        e_com = com_tab[idx];
        if (lz_en && idx > 0 && m_disp < pow10[idx]) e_data = 8'hFF;
        else e_data = seg_tab[(m_disp / pow10[idx]) % 10];
      end else begin
        e_com  = 4'b1111;
        e_data = 8'hFF;
      end
      e_ack = req1;
      if (n >= DIV && (n % DIV) == BLANK_CYC - 1 && ((n / DIV) % 4) == 0) begin
        // Source 1 is live while fewer than HOLD_TICKS ticks followed its latest request.
        src = (last_req >= 0) && ((n / DIV - (last_req + 1) / DIV) < HOLD_TICKS);
        v   = src ? last_val : int'(cnt0);
        if (v > 9999) v = 9999;
        m_disp = v;
        m_sel  = src;
      end
      if (req1) begin
        last_req = n;
        last_val = int'(val1);
      end
      n++;
    end
    #1;
    check("fnd_com", 16'(fnd_com), 16'(e_com));
    check("fnd_data", 16'(fnd_data), 16'(e_data));
    check("ack1", 16'(ack1), 16'(e_ack));
    check("sel", 16'(sel), 16'(m_sel));
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic pulse(input logic [13:0] v);
    req1 = 1'b1;
    val1 = v;
    step();
    req1 = 1'b0;
  endtask

  int r;
  int t1;

  initial begin
    rst   = 1'b1;
    cnt0  = 14'd1234;
    lz_en = 1'b0;
    req1  = 1'b0;
    val1  = 14'd0;
    run(3);
    rst = 1'b0;
    run(200);

    lz_en = 1'b1; cnt0 = 14'd7;    run(100);
    cnt0 = 14'd0;                  run(100);
    lz_en = 1'b0; cnt0 = 14'd12000; run(100);
    cnt0 = 14'd1111;               run(57);
    cnt0 = 14'd2222;               run(100);

    cnt0 = 14'd1234;
    pulse(14'd42);
    run(200);
    lz_en = 1'b1;
    pulse(14'd42);
    run(160);
    lz_en = 1'b0;

    // Retrigger a few clocks after the sixth tick of a hold.
    r = n;
    pulse(14'd9);
    t1 = ((r + 1) / DIV) * DIV + DIV - 1;
    while (n < t1 + 5 * DIV + 3) step();
    pulse(14'd5);
    run(200);

    // Request landing exactly on the expiry tick.
    r = n;
    pulse(14'd77);
    t1 = ((r + 1) / DIV) * DIV + DIV - 1;
    while (n < t1 + (HOLD_TICKS - 1) * DIV) step();
    pulse(14'd88);
    run(200);

    // Reset in the middle of a hold and of a digit.
    pulse(14'd300);
    run(25);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(120);

    for (int i = 0; i < 4000; i++) begin
      req1 = ($urandom_range(0, 39) == 0);
      if (req1) val1 = 14'($urandom_range(0, 16383));
      if ($urandom_range(0, 49) == 0) cnt0 = 14'($urandom_range(0, 16383));
      if ($urandom_range(0, 299) == 0) lz_en = ~lz_en;
      rst = ($urandom_range(0, 1499) == 0);
      step();
    end
    rst  = 1'b0;
    req1 = 1'b0;
    run(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
